// File: rtl/apb4_reg_bridge_pkg.sv
// Shared types for the APB4 register bridge: FSM state encoding, the
// captured-transfer record and the strobe-to-bit-enable expansion.
package apb4_bridge_pkg;

  // Widest configuration the captured-transfer record can hold.
  localparam int BRIDGE_ADDR_W_MAX = 32;
  localparam int BRIDGE_DATA_W_MAX = 64;
  localparam int BRIDGE_STRB_W_MAX = BRIDGE_DATA_W_MAX / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } bridge_state_t;

  // One APB transfer as latched at the access phase.
  typedef struct packed {
    logic                         is_wr;
    logic [BRIDGE_ADDR_W_MAX-1:0] addr;
    logic [BRIDGE_DATA_W_MAX-1:0] wdata;
    logic [BRIDGE_STRB_W_MAX-1:0] strb;
  } bridge_req_t;

  // Each byte strobe becomes eight identical bit enables.
  function automatic logic [BRIDGE_DATA_W_MAX-1:0] strb_to_biten(
    input logic [BRIDGE_STRB_W_MAX-1:0] strb
  );
    logic [BRIDGE_DATA_W_MAX-1:0] biten;
    for (int i = 0; i < BRIDGE_STRB_W_MAX; i++) begin
      biten[8*i +: 8] = {8{strb[i]}};
    end
    return biten;
  endfunction

endpackage

// File: rtl/apb4_reg_bridge_if.sv
// APB4 completer port plus register-block request bus, bundled so the
// bridge takes one interface port. slave = bridge view, master = the
// APB requester / register block environment view.
interface apb4_reg_bridge_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [DATA_WIDTH-1:0]     pwdata;
  logic [DATA_WIDTH/8-1:0]   pstrb;
  logic                      pready;
  logic [DATA_WIDTH-1:0]     prdata;
  logic                      pslverr;

  logic                      o_bus_req;
  logic                      o_bus_req_is_wr;
  logic [ADDR_WIDTH-1:0]     o_bus_addr;
  logic [DATA_WIDTH-1:0]     o_bus_wr_data;
  logic [DATA_WIDTH-1:0]     o_bus_wr_biten;
  logic                      bus_req_stall_wr;
  logic                      bus_req_stall_rd;
  logic                      bus_ready;
  logic [DATA_WIDTH-1:0]     bus_rd_data;
  logic                      bus_err;

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr,
    output o_bus_req, o_bus_req_is_wr, o_bus_addr, o_bus_wr_data, o_bus_wr_biten,
    input  bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_rd_data, bus_err
  );

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr,
    input  o_bus_req, o_bus_req_is_wr, o_bus_addr, o_bus_wr_data, o_bus_wr_biten,
    output bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_rd_data, bus_err
  );

endinterface

// File: rtl/apb4_reg_bridge_bus_timeout_ctr.sv
// Response watchdog for the bridge: cleared by load, counts while enabled,
// and flags expiry during the TIMEOUT_CYCLES-th enabled cycle.
module bus_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign expired = en && (cnt_q == LAST);

  // Count enabled cycles, saturating at the expiry value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/apb4_reg_bridge.sv
// APB4 completer bridging to a register-block request bus.
// Decodes an address window, honours per-direction request stalls, expands
// byte strobes into bit enables and returns a registered one-cycle response.
// Optional build macro APB4_REG_BRIDGE_TIMEOUT_EN adds a response watchdog.
module apb4_reg_bridge
  import apb4_bridge_pkg::*;
#(
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter int                        ADDR_WIDTH     = 8,
  parameter int                        DATA_WIDTH     = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        TIMEOUT_CYCLES = 16
) (
  input logic              clk,
  input logic              rst_n,
  apb4_reg_bridge_if.slave bus
);

  bridge_state_t               state_q;
  bridge_req_t                 req_q;
  logic                        drop_q;
  logic                        pready_q;
  logic                        pslverr_q;
  logic [DATA_WIDTH-1:0]       prdata_q;

  logic                        in_window;
  logic                        setup_acc;
  logic                        dir_stall;
  logic                        bus_fire;
  logic                        psel_lost;
  logic                        wr_fire;
  logic                        tmo_expired;
  logic [BRIDGE_DATA_W_MAX-1:0] biten_full;
  logic                        unused_bits;

  // BASE_ADDR is window-aligned, so the window test is an upper-bit match
  // and paddr - BASE_ADDR truncated is just the low ADDR_WIDTH bits.
  assign in_window = (bus.paddr >> ADDR_WIDTH) == (BASE_ADDR >> ADDR_WIDTH);
  assign setup_acc = bus.psel && bus.penable && !pready_q;
  assign dir_stall = req_q.is_wr ? bus.bus_req_stall_wr : bus.bus_req_stall_rd;
  assign bus_fire  = (state_q == REQ) && bus.psel && !dir_stall;
  assign psel_lost = drop_q || !bus.psel;
  assign wr_fire   = bus_fire && req_q.is_wr;

  assign biten_full = strb_to_biten(req_q.strb);

  assign bus.o_bus_req       = bus_fire;
  assign bus.o_bus_req_is_wr = wr_fire;
  assign bus.o_bus_addr      = bus_fire ? req_q.addr[ADDR_WIDTH-1:0] : '0;
  assign bus.o_bus_wr_data   = wr_fire ? req_q.wdata[DATA_WIDTH-1:0] : '0;
  assign bus.o_bus_wr_biten  = wr_fire ? biten_full[DATA_WIDTH-1:0] : '0;

  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;

  // The record is sized for the widest build; narrower builds leave bits idle.
  assign unused_bits = ^{req_q, biten_full};

`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
  logic tmo_load;
  logic tmo_en;

  assign tmo_load = (state_q == IDLE) && setup_acc && in_window;
  assign tmo_en   = (state_q == REQ) || (state_q == WAIT);

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmo_load),
    .en     (tmo_en),
    .expired(tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // Transfer sequencer; response registers are set only on entry to RESP,
  // so pready/prdata/pslverr are zero in every other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      drop_q    <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (setup_acc) begin
            req_q.is_wr <= bus.pwrite;
            req_q.addr  <= BRIDGE_ADDR_W_MAX'(bus.paddr[ADDR_WIDTH-1:0]);
            req_q.wdata <= BRIDGE_DATA_W_MAX'(bus.pwdata);
            req_q.strb  <= BRIDGE_STRB_W_MAX'(bus.pstrb);
            drop_q      <= 1'b0;
            if (in_window) begin
              state_q <= REQ;
            end else begin
              state_q   <= RESP;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (!bus.psel) begin
            state_q <= IDLE;
          end else if (bus_fire && bus.bus_ready) begin
            state_q   <= RESP;
            pready_q  <= 1'b1;
            pslverr_q <= bus.bus_err;
            prdata_q  <= req_q.is_wr ? '0 : bus.bus_rd_data;
          end else if (tmo_expired) begin
            state_q   <= RESP;
            pready_q  <= 1'b1;
            pslverr_q <= 1'b1;
          end else if (bus_fire) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.bus_ready || tmo_expired) begin
            if (psel_lost) begin
              state_q <= IDLE;
            end else begin
              state_q  <= RESP;
              pready_q <= 1'b1;
              if (bus.bus_ready) begin
                pslverr_q <= bus.bus_err;
                prdata_q  <= req_q.is_wr ? '0 : bus.bus_rd_data;
              end else begin
                pslverr_q <= 1'b1;
              end
            end
          end else if (!bus.psel) begin
            drop_q <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_reg_bridge.sv
// Self-checking bench for apb4_reg_bridge: directed cases followed by
// randomized APB transfers, each predicted by a timeline model of the
// transfer (setup, access, stall, response delay) and compared per cycle.
module tb_apb4_reg_bridge;

  localparam int          APB_AW = 32;
  localparam int          AW     = 8;
  localparam int          DW     = 32;
  localparam int          SW     = DW / 8;
  localparam logic [31:0] BASE   = 32'h0000_4000;
  localparam int          TMO    = 16;
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
  localparam int          TMO_EFF = TMO;
`else
  localparam int          TMO_EFF = 1 << 20;
`endif
  localparam int          NEVER  = 1 << 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb4_reg_bridge_if #(.APB_ADDR_WIDTH(APB_AW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  apb4_reg_bridge #(
    .APB_ADDR_WIDTH(APB_AW),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .BASE_ADDR     (BASE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_biten(input logic [SW-1:0] strb);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) m = m | (DW'(8'hFF) << (8 * i));
    end
    return m;
  endfunction

  task automatic drive_idle();
    bif.psel = 1'b0; bif.penable = 1'b0; bif.pwrite = 1'b0;
    bif.paddr = '0; bif.pwdata = '0; bif.pstrb = '0;
    bif.bus_req_stall_wr = 1'b0; bif.bus_req_stall_rd = 1'b0;
    bif.bus_ready = 1'b0; bif.bus_rd_data = '0; bif.bus_err = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_pready"}, 64'(bif.pready), 64'(0));
    check_val({tag, "_prdata"}, 64'(bif.prdata), 64'(0));
    check_val({tag, "_pslverr"}, 64'(bif.pslverr), 64'(0));
    check_val({tag, "_req"}, 64'({bif.o_bus_req, bif.o_bus_req_is_wr, bif.o_bus_addr}), 64'(0));
    check_val({tag, "_wdata"}, 64'(bif.o_bus_wr_data), 64'(0));
    check_val({tag, "_biten"}, 64'(bif.o_bus_wr_biten), 64'(0));
  endtask

  // One APB transfer. Cycle 0 = SETUP, cycle 1 = ACCESS; the register block
  // de-asserts the matching stall from cycle 2+stall, answers dly cycles
  // after the accepted request; psel/penable drop from cycle drop_at on.
  task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input int stall, input int dly,
                          input bit err, input logic [DW-1:0] rdata, input int drop_at);
    bit inwin, fire_ok, err_x, on, fire_now, rsp_now, other_stall;
    int f, rdy, p, nreq;
    logic [DW-1:0] rd_x;
    logic [31:0] off;
    inwin = (addr >= BASE) && (addr < BASE + 32'h100);
    off   = addr - BASE;
    f     = 2 + stall;
    rdy   = f + dly;
    if (!inwin) begin
      p = 2; fire_ok = 1'b0; err_x = 1'b1; rd_x = '0;
    end else if (rdy > TMO_EFF + 1) begin
      p = 2 + TMO_EFF; fire_ok = (f <= TMO_EFF + 1); err_x = 1'b1; rd_x = '0;
    end else begin
      p = rdy + 1; fire_ok = 1'b1; err_x = err; rd_x = wr ? '0 : rdata;
    end
    nreq = 0;
    for (int c = 0; c <= p; c++) begin
      on = (c < drop_at);
      bif.psel    = on;
      bif.penable = on && (c >= 1);
      bif.paddr   = addr;
      bif.pwrite  = wr;
      bif.pwdata  = wdata;
      bif.pstrb   = strb;
      other_stall = 1'($urandom_range(0, 1));
      if (wr) begin
        bif.bus_req_stall_wr = (c >= 2) && (c < 2 + stall);
        bif.bus_req_stall_rd = other_stall;
      end else begin
        bif.bus_req_stall_rd = (c >= 2) && (c < 2 + stall);
        bif.bus_req_stall_wr = other_stall;
      end
      if (inwin) bif.bus_ready = (c == rdy) || ((c == 0) && ($urandom_range(0, 1) == 1));
      else       bif.bus_ready = 1'($urandom_range(0, 1));
      bif.bus_rd_data = (c == rdy) ? rdata : DW'($urandom);
      bif.bus_err     = (c == rdy) ? err : 1'($urandom_range(0, 1));
      @(negedge clk);
      fire_now = fire_ok && (c == f) && (f < drop_at);
      rsp_now  = (c == p) && (p < drop_at);
      check_val("pready", 64'(bif.pready), 64'(rsp_now));
      check_val("prdata", 64'(bif.prdata), rsp_now ? 64'(rd_x) : 64'(0));
      check_val("pslverr", 64'(bif.pslverr), rsp_now ? 64'(err_x) : 64'(0));
      check_val("bus_req", 64'(bif.o_bus_req), 64'(fire_now));
      if (bif.o_bus_req === 1'b1) nreq++;
      if (fire_now) begin
        check_val("bus_is_wr", 64'(bif.o_bus_req_is_wr), 64'(wr));
        check_val("bus_addr", 64'(bif.o_bus_addr), 64'(off[AW-1:0]));
        check_val("bus_biten", 64'(bif.o_bus_wr_biten), wr ? 64'(exp_biten(strb)) : 64'(0));
        if (wr) check_val("bus_wdata", 64'(bif.o_bus_wr_data), 64'(wdata));
      end else begin
        check_val("bus_idle_ctl", 64'({bif.o_bus_req_is_wr, bif.o_bus_addr}), 64'(0));
        check_val("bus_idle_wd", 64'(bif.o_bus_wr_data), 64'(0));
        check_val("bus_idle_be", 64'(bif.o_bus_wr_biten), 64'(0));
      end
      @(posedge clk);
      #1;
    end
    check_val("req_count", 64'(nreq), (fire_ok && (f < drop_at)) ? 64'(1) : 64'(0));
    drive_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int r;
    drive_idle();
    rst_n = 1'b0;
    bif.psel = 1'b1; bif.penable = 1'b1; bif.bus_ready = 1'b1; bif.bus_rd_data = '1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    apb_xfer(BASE + 32'h04, 1'b1, 32'hDEADBEEF, 4'b0011, 0, 0, 1'b0, 32'h0, NEVER);
    apb_xfer(BASE + 32'h08, 1'b0, 32'h0, 4'b0000, 0, 3, 1'b0, 32'h12345678, NEVER);
    apb_xfer(BASE + 32'h0C, 1'b0, 32'h0, 4'b0000, 4, 0, 1'b0, 32'hA5A55A5A, NEVER);
    apb_xfer(BASE + 32'h100, 1'b0, 32'h0, 4'b0000, 0, 0, 1'b0, 32'hFFFFFFFF, NEVER);
    apb_xfer(BASE - 32'h4, 1'b1, 32'h11111111, 4'b1111, 0, 0, 1'b0, 32'h0, NEVER);
    apb_xfer(BASE + 32'h10, 1'b1, 32'hCAFEF00D, 4'b1100, 1, 1, 1'b1, 32'h0, NEVER);
    apb_xfer(BASE + 32'hFC, 1'b1, 32'h01234567, 4'b1111, 2, 0, 1'b0, 32'h0, NEVER);
    apb_xfer(BASE + 32'h20, 1'b1, 32'h55AA55AA, 4'b0101, 0, 4, 1'b0, 32'h0, 3);
    apb_xfer(BASE + 32'h24, 1'b0, 32'h0, 4'b0000, 3, 0, 1'b0, 32'h87654321, 3);
    apb_xfer(BASE + 32'h28, 1'b0, 32'h0, 4'b0000, 0, 0, 1'b1, 32'h0BADF00D, NEVER);
`ifdef APB4_REG_BRIDGE_TIMEOUT_EN
    apb_xfer(BASE + 32'h30, 1'b0, 32'h0, 4'b0000, 0, NEVER, 1'b0, 32'h0, NEVER);
    apb_xfer(BASE + 32'h34, 1'b1, 32'h1, 4'b0001, NEVER, 0, 1'b0, 32'h0, NEVER);
`endif

    // Reset asserted while the bridge waits for a response.
    bif.psel = 1'b1; bif.penable = 1'b0; bif.pwrite = 1'b0; bif.paddr = BASE + 32'h40;
    @(posedge clk); #1;
    bif.penable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_wait_req", 64'(bif.o_bus_req), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    bif.bus_ready = 1'b1; bif.bus_rd_data = 32'hFEEDFACE;
    #1;
    check_quiet("rst_wait");
    @(posedge clk); #1;
    check_quiet("rst_hold");
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(BASE + 32'h44, 1'b0, 32'h0, 4'b0000, 0, 1, 1'b0, 32'h600DCAFE, NEVER);

    // Randomized transfers, occasionally separated by idle cycles.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)      a = BASE + 32'($urandom_range(0, 255));
      else if (r < 8) a = BASE + 32'h100 + 32'($urandom_range(0, 4095));
      else            a = BASE - 32'h1 - 32'($urandom_range(0, 16383));
      apb_xfer(a, 1'($urandom_range(0, 1)), DW'($urandom), SW'($urandom_range(0, 15)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
               ($urandom_range(0, 3) == 0), DW'($urandom), NEVER);
      if ($urandom_range(0, 2) == 0) begin
        bif.bus_ready = 1'b1;
        bif.bus_rd_data = DW'($urandom);
        @(negedge clk);
        check_quiet("gap");
        @(posedge clk); #1;
        drive_idle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
